// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon-MM RAM responder.
package mips_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam int          BYTE_LANES   = 4;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  // Taps 16,14,13,11 in 1-based LFSR numbering are state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mips_ram_lfsr.sv
// 16-bit Fibonacci LFSR that steps once per accepted transfer; used for random wait-states.
module mips_ram_lfsr
  import mips_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/mips_avalon_ram_slave.sv
// Avalon-MM word RAM responder with wait-states, byte lanes and a sticky bus_err.
// Define RAM_RANDOM_WAIT_EN to add LFSR-driven random wait-states per transfer.
module mips_avalon_ram_slave
  import mips_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        bus_err
);

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [31:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [31:0]           addr_q, wdata_q;
  logic                  read_q, write_q, inr_q;
  logic [3:0]            be_q;
  logic [ADDR_WIDTH-1:0] idx_q;

  logic                  req, lat_en, commit, inr_in;
  logic [29:0]           word_off;
  logic [ADDR_WIDTH-1:0] idx_in;
  logic [3:0]            load_cnt;

  assign req      = read | write;
  // Word offset from the window base, 30-bit unsigned wrap (below-window addresses land far out).
  assign word_off = address[31:2] - BASE_ADDR[31:2];
  assign idx_in   = word_off[ADDR_WIDTH-1:0];
  assign inr_in   = (word_off[29:ADDR_WIDTH] == '0);

`ifdef RAM_RANDOM_WAIT_EN
  logic [15:0] lfsr_state;

  mips_ram_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (reset),
    .step_i  (lat_en),
    .state_o (lfsr_state)
  );

  assign load_cnt = lfsr_state[3:0] | WAIT_INIT;
`else
  assign load_cnt = WAIT_INIT;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    lat_en      = 1'b0;
    commit      = 1'b0;
    waitrequest = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          waitrequest = 1'b1;
          lat_en      = 1'b1;
          state_d     = BUSY;
          cnt_d       = load_cnt;
          rdata_d     = inr_in ? mem[idx_in] : 32'h0;
          if (!inr_in || (address[1:0] != 2'b00) || (read && write)) err_d = 1'b1;
        end
      end
      BUSY: begin
        waitrequest = (cnt_q != 4'd0);
        if (!req) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          if ((address != addr_q) || (read != read_q) || (write != write_q)) err_d = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d = IDLE;
            // Read wins when both strobes were latched, so such a transfer never writes.
            commit  = write_q & ~read_q & inr_q;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            rdata_d = inr_q ? mem[idx_q] : 32'h0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      inr_q   <= 1'b0;
      be_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (lat_en) begin
        addr_q  <= address;
        wdata_q <= writedata;
        read_q  <= read;
        write_q <= write;
        inr_q   <= inr_in;
        be_q    <= byteenable;
        idx_q   <= idx_in;
      end
    end
  end

  // NOTE: the RAM array has no reset; contents survive reset and it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < BYTE_LANES; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign readdata = rdata_q;
  assign bus_err  = err_q;

endmodule

// File: tb/tb_mips_avalon_ram_slave.sv
// Self-checking bench: instance 0 has no wait-states, instance 1 has three.
module tb_mips_avalon_ram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address [2];
  logic [31:0] wdata   [2];
  logic [3:0]  be      [2];
  logic [1:0]  rd, wr;

  logic        wreq0, wreq1, err0, err1;
  logic [31:0] rdat0, rdat1;
  logic        waitreq [2];
  logic        err     [2];
  logic [31:0] rdata   [2];

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  always_comb begin
    waitreq[0] = wreq0; waitreq[1] = wreq1;
    err[0]     = err0;  err[1]     = err1;
    rdata[0]   = rdat0; rdata[1]   = rdat1;
  end

  mips_avalon_ram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(32'hBFC00000), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .address(address[0]), .read(rd[0]), .write(wr[0]),
    .writedata(wdata[0]), .byteenable(be[0]), .waitrequest(wreq0), .readdata(rdat0), .bus_err(err0)
  );

  mips_avalon_ram_slave #(.ADDR_WIDTH(12), .BASE_ADDR(32'hBFC00000), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(rst_n), .address(address[1]), .read(rd[1]), .write(wr[1]),
    .writedata(wdata[1]), .byteenable(be[1]), .waitrequest(wreq1), .readdata(rdat1), .bus_err(err1)
  );

  typedef struct packed {
    bit          rst;
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(bit rst, bit r, bit w, logic [31:0] a, logic [31:0] d,
                              logic [3:0] b, logic [31:0] exp_rd, bit exp_err);
    vec_t v;
    v.rst = rst; v.r = r; v.w = w; v.a = a; v.d = d; v.b = b;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    address[k] = a; rd[k] = r; wr[k] = w; wdata[k] = d; be[k] = b;
  endtask

  // Counts waitrequest-high cycles, captures readdata in the accepting cycle, then releases.
  task automatic wait_done(input int k, output int waits, output logic [31:0] got, output bit done);
    waits = 0; done = 1'b0; got = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!waitreq[k]) begin
        got = rdata[k]; done = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    if (done) @(posedge clk);
    #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  task automatic xfer(input int k, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b,
                      output int waits, output logic [31:0] got, output bit done);
    @(negedge clk);
    drive(k, r, w, a, d, b);
    wait_done(k, waits, got, done);
  endtask

  task automatic wr_word(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    int w; logic [31:0] g; bit done;
    xfer(k, 1'b0, 1'b1, a, d, b, w, g, done);
    check("write_done", 32'(done), 32'd1);
  endtask

  task automatic rd_word(input int k, input logic [31:0] a, input logic [31:0] e,
                         input string name, output int waits);
    logic [31:0] g, ex; bit done;
    exp_q.push_back(e);
    xfer(k, 1'b1, 1'b0, a, 32'h0, 4'h0, waits, g, done);
    ex = exp_q.pop_front();
    check({name, "_done"}, 32'(done), 32'd1);
    if (done) check({name, "_data"}, g, ex);
  endtask

  vec_t vecs [22];

  initial begin
    int          waits;
    logic [31:0] got, ex;
    bit          done;
    vec_t        v;

    rst_n = 1'b0;
    rd = '0; wr = '0;
    for (int k = 0; k < 2; k++) begin
      address[k] = '0; wdata[k] = '0; be[k] = '0;
    end

    vecs[0]  = mk(0, 0, 1, 32'hBFC00010, 32'hDEADBEEF, 4'hF, 32'h0,        0);
    vecs[1]  = mk(0, 1, 0, 32'hBFC00010, 32'h0,        4'h0, 32'hDEADBEEF, 0);
    vecs[2]  = mk(0, 0, 1, 32'hBFC00010, 32'h00AA0000, 4'h4, 32'h0,        0);
    vecs[3]  = mk(0, 1, 0, 32'hBFC00010, 32'h0,        4'h0, 32'hDEAABEEF, 0);
    vecs[4]  = mk(0, 0, 1, 32'hBFC00014, 32'hCAFEF00D, 4'hF, 32'h0,        0);
    vecs[5]  = mk(0, 0, 1, 32'hBFC00014, 32'h11111111, 4'h0, 32'h0,        0);
    vecs[6]  = mk(0, 1, 0, 32'hBFC00014, 32'h0,        4'h0, 32'hCAFEF00D, 0);
    vecs[7]  = mk(0, 0, 1, 32'hBFC00018, 32'h01234567, 4'hF, 32'h0,        0);
    vecs[8]  = mk(0, 0, 1, 32'hBFC00018, 32'hAABBCCDD, 4'h9, 32'h0,        0);
    vecs[9]  = mk(0, 1, 0, 32'hBFC00018, 32'h0,        4'h0, 32'hAA2345DD, 0);
    vecs[10] = mk(0, 0, 1, 32'hBFC03FFC, 32'h5A5A5A5A, 4'hF, 32'h0,        0);
    vecs[11] = mk(0, 1, 0, 32'hBFC03FFC, 32'h0,        4'h0, 32'h5A5A5A5A, 0);
    vecs[12] = mk(0, 0, 1, 32'hBFC00000, 32'h0F0F0F0F, 4'hF, 32'h0,        0);
    vecs[13] = mk(0, 1, 0, 32'hBFC00000, 32'h0,        4'h0, 32'h0F0F0F0F, 0);
    vecs[14] = mk(1, 1, 0, 32'h00000000, 32'h0,        4'h0, 32'h0,        1);
    vecs[15] = mk(1, 1, 0, 32'hBFC00012, 32'h0,        4'h0, 32'hDEAABEEF, 1);
    vecs[16] = mk(1, 1, 1, 32'hBFC00010, 32'h0,        4'hF, 32'hDEAABEEF, 1);
    vecs[17] = mk(0, 1, 0, 32'hBFC00010, 32'h0,        4'h0, 32'hDEAABEEF, 1);
    vecs[18] = mk(1, 0, 1, 32'hBFC04000, 32'h77777777, 4'hF, 32'h0,        1);
    vecs[19] = mk(0, 1, 0, 32'hBFC04000, 32'h0,        4'h0, 32'h0,        1);
    vecs[20] = mk(1, 1, 0, 32'hBFC03FFC, 32'h0,        4'h0, 32'h5A5A5A5A, 0);
    vecs[21] = mk(0, 1, 0, 32'hBFC00014, 32'h0,        4'h0, 32'hCAFEF00D, 0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_waitreq", 32'(waitreq[0]), 32'd0);
    check("rst_rdata",   rdata[0],        32'h0);
    check("rst_err",     32'(err[0]),     32'd0);
    check("rst_err1",    32'(err[1]),     32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Vector table on the zero-wait instance
    for (int i = 0; i < 22; i++) begin
      v = vecs[i];
      if (v.rst) do_reset();
      if (v.r) exp_q.push_back(v.exp_rd);
      xfer(0, v.r, v.w, v.a, v.d, v.b, waits, got, done);
      check($sformatf("v%0d_done", i), 32'(done), 32'd1);
`ifndef RAM_RANDOM_WAIT_EN
      check($sformatf("v%0d_waits", i), 32'(waits), 32'd1);
`endif
      if (v.r) begin
        ex = exp_q.pop_front();
        if (done) check($sformatf("v%0d_rdata", i), got, ex);
      end
      check($sformatf("v%0d_err", i), 32'(err[0]), 32'(v.exp_err));
    end

    // Three wait-states: waitrequest high for four cycles, data in the fifth
    do_reset();
    wr_word(1, 32'hBFC00020, 32'h31415926, 4'hF);
    rd_word(1, 32'hBFC00020, 32'h31415926, "ws3", waits);
`ifndef RAM_RANDOM_WAIT_EN
    check("ws3_waits", 32'(waits), 32'd4);
`else
    check("ws3_waits_range", 32'((waits >= 4) && (waits <= 16)), 32'd1);
`endif
    check("ws3_err", 32'(err[1]), 32'd0);

    // Address changed mid-transfer: latched word returned, error raised
    wr_word(1, 32'hBFC00030, 32'hAAAA0001, 4'hF);
    wr_word(1, 32'hBFC00034, 32'hBBBB0002, 4'hF);
    exp_q.push_back(32'hAAAA0001);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'hBFC00030, 32'h0, 4'h0);
    @(negedge clk);
    address[1] = 32'hBFC00034;
    wait_done(1, waits, got, done);
    ex = exp_q.pop_front();
    check("addr_chg_done", 32'(done), 32'd1);
    if (done) check("addr_chg_rdata", got, ex);
    check("addr_chg_err", 32'(err[1]), 32'd1);

    // Request dropped mid-transfer: abort to idle with error
    do_reset();
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'hBFC00030, 32'h0, 4'h0);
    @(negedge clk);
    rd[1] = 1'b0;
    @(negedge clk); #1;
    check("drop_waitreq", 32'(waitreq[1]), 32'd0);
    check("drop_err", 32'(err[1]), 32'd1);
    do_reset();
    rd_word(1, 32'hBFC00030, 32'hAAAA0001, "after_drop", waits);

    // Reset during a write: no commit, registers cleared, waitrequest follows request
    wr_word(1, 32'hBFC00040, 32'h13572468, 4'hF);
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 32'hBFC00040, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_waitreq", 32'(waitreq[1]), 32'd1);
    check("rst_mid_err",     32'(err[1]),     32'd0);
    check("rst_mid_rdata",   rdata[1],        32'h0);
    @(negedge clk);
    wr[1] = 1'b0;
    #1;
    check("rst_mid_idle_waitreq", 32'(waitreq[1]), 32'd0);
    rst_n = 1'b1;
    rd_word(1, 32'hBFC00040, 32'h13572468, "rst_mid_word", waits);
    check("rst_mid_err_after", 32'(err[1]), 32'd0);

`ifdef RAM_RANDOM_WAIT_EN
    begin
      logic [31:0] model [16];
      int wmin = 100;
      int wmax = -1;
      do_reset();
      for (int i = 0; i < 16; i++) begin
        model[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        wr_word(0, 32'hBFC00100 + 32'(4 * i), model[i], 4'hF);
      end
      for (int n = 0; n < 100; n++) begin
        int idx;
        idx = int'($urandom_range(0, 15));
        rd_word(0, 32'hBFC00100 + 32'(4 * idx), model[idx], "rand", waits);
        check("rand_waits_range", 32'((waits >= 1) && (waits <= 16)), 32'd1);
        if (waits < wmin) wmin = waits;
        if (waits > wmax) wmax = waits;
      end
      check("rand_waits_vary", 32'(wmax > wmin), 32'd1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
